// File: rtl/fifo_pkg.sv
// fifo_pkg: shared error-bit positions, error vector type and count-width helper
package fifo_pkg;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

    typedef logic [1:0] err_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: register-array dual-port memory, synchronous write, asynchronous read
module fifo_ram #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // storage is never reset; only accepted writes touch it
    always_ff @(posedge i_clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with flags, count and sticky errors; SYNC_FIFO_FWFT_EN selects first-word-fall-through output
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                    i_wclk,
    input  logic                    i_reset,
    input  logic                    i_wr_en,
    input  logic [WIDTH-1:0]        i_din,
    input  logic                    i_rd_en,
    input  logic                    i_err_clr,
    output logic [WIDTH-1:0]        o_dout,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic [cnt_w(DEPTH)-1:0] o_count,
    output logic [1:0]              o_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_count;
    logic             r_full, r_empty, r_af, r_ae;
    err_t             r_err;
    logic             w_rd_acc, w_wr_acc;
    logic [CW-1:0]    w_cnt_nxt;
    err_t             w_err_set;
    logic [WIDTH-1:0] w_rdata;

    // a full FIFO still takes a write when a read frees a slot in the same cycle
    assign w_rd_acc  = i_rd_en && !r_empty;
    assign w_wr_acc  = i_wr_en && (!r_full || w_rd_acc);
    assign w_cnt_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

    assign w_err_set[ERR_OVF] = i_wr_en && !w_wr_acc;
    assign w_err_set[ERR_UNF] = i_rd_en && r_empty;

    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .i_clk   (i_wclk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wp),
        .i_wdata (i_din),
        .i_raddr (r_rp),
        .o_rdata (w_rdata)
    );

    // pointers, count and flags; flags come from the next count so they move with it
    always_ff @(posedge i_wclk or negedge i_reset) begin
        if (!i_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
        end else begin
            r_wp    <= w_wr_acc ? r_wp + AW'(1) : r_wp;
            r_rp    <= w_rd_acc ? r_rp + AW'(1) : r_rp;
            r_count <= w_cnt_nxt;
            r_full  <= w_cnt_nxt == CW'(DEPTH);
            r_empty <= w_cnt_nxt == '0;
            r_af    <= w_cnt_nxt >= CW'(AF_LEVEL);
            r_ae    <= w_cnt_nxt <= CW'(AE_LEVEL);
        end
    end

    // sticky error bits; a new error in the clearing cycle wins over the clear
    always_ff @(posedge i_wclk or negedge i_reset) begin
        if (!i_reset) r_err <= '0;
        else          r_err <= (r_err & {2{~i_err_clr}}) | w_err_set;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign o_dout = w_rdata;
`else
    logic [WIDTH-1:0] r_dout;

    // registered read data, held while no read is accepted
    always_ff @(posedge i_wclk or negedge i_reset) begin
        if (!i_reset)      r_dout <= '0;
        else if (w_rd_acc) r_dout <= w_rdata;
    end

    assign o_dout = r_dout;
`endif

    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_af;
    assign o_almost_empty = r_ae;
    assign o_count        = r_count;
    assign o_error        = r_err;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed and random stimulus against a queue-based reference model
module tb_sync_fifo_param;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset, wr_en, rd_en, err_clr;
    logic [W-1:0]  din, dout;
    logic          full, empty, af, ae;
    logic [CW-1:0] count;
    logic [1:0]    error;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] q[$];
    logic [1:0]   m_err;
    logic [W-1:0] m_dout;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .i_wclk         (clk),
        .i_reset        (reset),
        .i_wr_en        (wr_en),
        .i_din          (din),
        .i_rd_en        (rd_en),
        .i_err_clr      (err_clr),
        .o_dout         (dout),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (af),
        .o_almost_empty (ae),
        .o_count        (count),
        .o_error        (error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ":count"}, 32'(count), 32'(n));
        chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ":full"},  32'(full),  32'(n == D));
        chk({tag, ":af"},    32'(af),    32'(n >= AF));
        chk({tag, ":ae"},    32'(ae),    32'(n <= AE));
        chk({tag, ":error"}, 32'(error), 32'(m_err));
`ifdef SYNC_FIFO_FWFT_EN
        if (n > 0) chk({tag, ":dout"}, 32'(dout), 32'(q[0]));
`else
        chk({tag, ":dout"}, 32'(dout), 32'(m_dout));
`endif
    endtask

    task automatic step(input string tag, input logic w, input logic [W-1:0] d,
                        input logic r, input logic c);
        int  n;
        bit  ra, wa;
        wr_en = w; din = d; rd_en = r; err_clr = c;
        @(posedge clk);
        n  = q.size();
        ra = r && n > 0;
        wa = w && (n < D || ra);
        if (c) m_err = 2'b00;
        if (w && !wa) m_err[0] = 1'b1;
        if (r && n == 0) m_err[1] = 1'b1;
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(d);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        q.delete();
        m_err  = 2'b00;
        m_dout = '0;
        check_all("rst_async");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check_all("rst_release");
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
        #2;
        do_reset();

        step("basic_w0", 1, 4'hB, 0, 0);
        step("basic_w1", 1, 4'h7, 0, 0);
        step("basic_r0", 0, '0, 1, 0);
        step("basic_r1", 0, '0, 1, 0);

        for (int i = 0; i < D; i++) step("fill", 1, W'(i), 0, 0);
        step("ovf", 1, 4'hF, 0, 0);
        for (int i = 0; i < D; i++) step("drain", 0, '0, 1, 0);

        step("clr0", 0, '0, 0, 1);
        step("unf", 0, '0, 1, 0);
        step("clr1", 0, '0, 0, 1);
        step("clr_unf", 0, '0, 1, 1);
        step("clr2", 0, '0, 0, 1);

        for (int i = 0; i < D; i++) step("fill2", 1, W'(D - 1 - i), 0, 0);
        step("full_both", 1, 4'hE, 1, 0);
        for (int i = 0; i < D; i++) step("drain2", 0, '0, 1, 0);
        step("empty_both", 1, 4'h5, 1, 0);
        step("rd_last", 0, '0, 1, 0);
        step("clr3", 0, '0, 0, 1);

        for (int i = 0; i < 3; i++) step("wrap_pre", 1, W'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) step("wrap", 1, W'($urandom), 1, 0);
        for (int i = 0; i < 3; i++) step("wrap_post", 0, '0, 1, 0);

        for (int i = 0; i < 5; i++) step("mid_fill", 1, W'(i + 3), 0, 0);
        do_reset();
        step("post_rst_w", 1, 4'hA, 0, 0);
        step("post_rst_r", 0, '0, 1, 0);

        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 1)), W'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, next generation of the team's 4-bit FIFO. It buffers WIDTH-bit words between a producer and a consumer on the same clock. It adds:
- depth and width parameters
- full/empty and programmable almost-full/almost-empty flags
- an occupancy count
- sticky overflow/underflow error reporting

It sits between datapath stages wherever rate smoothing is needed.

## Interface
- WIDTH, 4: data word width in bits, ≥1.
- DEPTH, 8: number of entries; power of two, ≥4.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL.
- wclk  in  1  sole clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- rd_en  in  1  read request.
- err_clr  in  1  synchronous clear of both error bits.
- dout  out  WIDTH  read data.
- full, empty  out  1  count==DEPTH / count==0.
- almost_full, almost_empty  out  1  threshold flags.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- error  out  2  bit0 overflow, bit1 underflow; sticky.

## Operation
- **Storage:** DEPTH×WIDTH array. Write pointer wp and read pointer rp are $clog2(DEPTH) bits each and wrap modulo DEPTH naturally.
- **Write accepted:** wr_en && (!full || rd_accepted). Stores din at wp, then wp+1.
- **Read accepted:** rd_en && !empty. Advances rp by 1.
- **Count:** count += wr_acc − rd_acc.
  - Both accepted → count unchanged.
  - Full + wr_en + rd_en → both accepted.
  - Empty + wr_en + rd_en → write accepted, read rejected.
- **Overflow:** wr_en && !wr_acc sets error[0].
- **Underflow:** rd_en && empty sets error[1].
- **Error hold and clear:**
  - Error bits hold until err_clr.
  - err_clr clears both bits.
  - If a new error occurs in the same cycle as err_clr, that error bit is set (set wins).
- **Rejected operations:** change no pointer, count or storage.
- **Flags:** all flags are registered, derived from the next-state count, so they change on the same edge as count.

## Timing
- **Reset values (reset=0, asynchronous):**
  - wp=rp=0, count=0, error=0, dout=0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - Storage contents are not reset.
- **Reset mid-operation:** contents are discarded. The first word read after reset is the first word written after reset.
- **Standard mode:** dout is registered. A read accepted at edge N presents the word at edge N (visible in cycle N+1). dout holds its value when no read is accepted.
- **Write-to-read latency:** a write at edge N makes empty=0 after edge N. The earliest read is then accepted at edge N+1.
- **Wrap-around:** after DEPTH writes and DEPTH reads, wp=rp=0 and data order is preserved.

## Configuration
- **SYNC_FIFO_FWFT_EN defined:** first-word-fall-through mode.
  - dout continuously shows the word at rp whenever empty=0.
  - rd_en acknowledges (pops) that word; dout changes to the next entry after the edge.
  - A write into an empty FIFO at edge N appears on dout after edge N.
  - dout is don't-care while empty.
- **Undefined:** standard registered-read mode as described in Timing.
- Flags, count and error behaviour are identical in both modes.

## Structure
- **Package fifo_pkg:**
  - localparams ERR_OVF=0, ERR_UNF=1.
  - typedef for the error vector.
  - function for count width ($clog2(DEPTH)+1).
- **Sub-module fifo_ram:**
  - Register-array dual-port memory.
  - Synchronous write, asynchronous read by address, parameters WIDTH/DEPTH.
  - sync_fifo_param holds pointers, count, flags, errors and the dout register.

## Test plan
Defaults: WIDTH=4, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
- **Reset/basic:** reset low for 2 cycles, release, write 4'hB then 4'h7, read twice → dout 4'hB then 4'h7; count 0→1→2→1→0; empty returns to 1.
- **Fill/overflow:** write 8 words 0..7 → full=1 and almost_full=1 at count 6; 9th write → error=2'b01, count stays 8; read all → 0..7 in order.
- **Underflow/clear:** rd_en on empty → error=2'b10, dout unchanged; err_clr pulse → error=0; err_clr plus another underflow in the same cycle → error[1]=1.
- **Simultaneous:**
  - Full + wr_en + rd_en → count stays 8, oldest word out, new word stored last.
  - Empty + both → count 1, error[1]=1.
- **Wrap:** 20 interleaved write/read cycles with count held at 3 → output sequence equals input sequence; pointers wrap cleanly.
- **Reset mid-stream:** with count=5, assert reset → all outputs at reset values immediately; subsequent write 4'hA then read returns 4'hA. Repeat all scenarios with SYNC_FIFO_FWFT_EN defined, checking dout valid same cycle as empty=0.
